// File: rtl/hazard_control_unit_if.sv
// Hazard controller bus: decode/execute side-band signals seen by the hazard
// unit and the stall/invalidate/event-count outputs it returns.
//   slave  : used by hazard_control_unit (consumes pipeline fields, drives stalls)
//   master : used by the pipeline side (drives fields, observes stalls)
// Signals:
//   flush_pipeline_i          redirect from branch/writeback (1 = flush)
//   ex_mem_read_en_i          EX instruction is a valid load
//   ex_reg_dest_addr_i        EX destination register
//   dec_is_valid_i            decode slot holds a valid instruction
//   dec_src_used_i            per-source read enables [0]=src1 [1]=src2 [2]=src3
//   dec_reg_{1,2,3}_source_addr_i  decode source registers
//   stall_fetch_o / stall_decode_o hold fetch and decode
//   hazard_detector_invalidate_o   bubble into EX
//   stall_count_o / flush_count_o  saturating event counters
interface hazard_control_unit_if #(
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 16
);
    logic                   flush_pipeline_i;
    logic                   ex_mem_read_en_i;
    logic [ADDR_WIDTH-1:0]  ex_reg_dest_addr_i;
    logic                   dec_is_valid_i;
    logic [2:0]             dec_src_used_i;
    logic [ADDR_WIDTH-1:0]  dec_reg_1_source_addr_i;
    logic [ADDR_WIDTH-1:0]  dec_reg_2_source_addr_i;
    logic [ADDR_WIDTH-1:0]  dec_reg_3_source_addr_i;
    logic                   stall_fetch_o;
    logic                   stall_decode_o;
    logic                   hazard_detector_invalidate_o;
    logic [COUNT_WIDTH-1:0] stall_count_o;
    logic [COUNT_WIDTH-1:0] flush_count_o;

    modport slave (
        input  flush_pipeline_i, ex_mem_read_en_i, ex_reg_dest_addr_i,
               dec_is_valid_i, dec_src_used_i, dec_reg_1_source_addr_i,
               dec_reg_2_source_addr_i, dec_reg_3_source_addr_i,
        output stall_fetch_o, stall_decode_o, hazard_detector_invalidate_o,
               stall_count_o, flush_count_o
    );

    modport master (
        output flush_pipeline_i, ex_mem_read_en_i, ex_reg_dest_addr_i,
               dec_is_valid_i, dec_src_used_i, dec_reg_1_source_addr_i,
               dec_reg_2_source_addr_i, dec_reg_3_source_addr_i,
        input  stall_fetch_o, stall_decode_o, hazard_detector_invalidate_o,
               stall_count_o, flush_count_o
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller at the decode/execute boundary. Detects load-use hazards
// between EX and decode, inserts a one-cycle stall plus bubble, and holds the
// EX invalidate through a flush drain window. Keeps saturating stall/flush
// event counters for performance debug.
// Ports:
//   clk_i    system clock, all state on posedge
//   reset_i  synchronous active-high reset
//   hz       hazard bus (slave side), see hazard_control_unit_if
//
// state          | meaning
// ST_IDLE        | no hazard in progress; flush or load-use hit acted on here
// ST_LOAD_STALL  | bubble sits in EX for one cycle; hit suppressed
// ST_FLUSH_DRAIN | invalidate held while drain counter runs down
module hazard_control_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    hazard_control_unit_if.slave  hz
);

    localparam logic       FLUSH_PIPELINE = 1'b1;
    localparam bit         HAS_DRAIN      = (FLUSH_CYCLES > 1);
    localparam logic [3:0] DRAIN_LOAD     = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD_STALL  = 2'd1,
        ST_FLUSH_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    logic flush;
    logic hit;
    logic stall_d, inv_d;
    logic stall_inc, flush_inc;

    assign flush = (hz.flush_pipeline_i == FLUSH_PIPELINE);

    always_comb begin
        hit = hz.ex_mem_read_en_i & hz.dec_is_valid_i &
              ((hz.dec_src_used_i[0] & (hz.dec_reg_1_source_addr_i == hz.ex_reg_dest_addr_i)) |
               (hz.dec_src_used_i[1] & (hz.dec_reg_2_source_addr_i == hz.ex_reg_dest_addr_i)) |
               (hz.dec_src_used_i[2] & (hz.dec_reg_3_source_addr_i == hz.ex_reg_dest_addr_i)));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = 1'b0;
        inv_d     = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD_STALL: begin
                if (flush) begin
                    // With a single-cycle flush there is no drain state to visit.
                    inv_d     = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = HAS_DRAIN ? ST_FLUSH_DRAIN : ST_IDLE;
                    cnt_d     = HAS_DRAIN ? DRAIN_LOAD : 4'd0;
                end else if (state_q == ST_IDLE && hit) begin
                    stall_d   = 1'b1;
                    inv_d     = 1'b1;
                    stall_inc = 1'b1;
                    state_d   = ST_LOAD_STALL;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_FLUSH_DRAIN: begin
                inv_d = 1'b1;
                if (flush) begin
                    flush_inc = 1'b1;
                    cnt_d     = DRAIN_LOAD;
                end else if (cnt_q <= 4'd1) begin
                    state_d   = ST_IDLE;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_inc && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + COUNT_WIDTH'(1);
            if (flush_inc && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + COUNT_WIDTH'(1);
        end
    end

    // Outputs are combinational so the pipeline registers see them at the next edge.
    assign hz.stall_fetch_o                = stall_d & ~reset_i;
    assign hz.stall_decode_o               = stall_d & ~reset_i;
    assign hz.hazard_detector_invalidate_o = inv_d & ~reset_i;
    assign hz.stall_count_o                = stall_cnt_q;
    assign hz.flush_count_o                = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_control_unit_if #(.ADDR_WIDTH(5), .COUNT_WIDTH(16)) bus_a ();
    hazard_control_unit_if #(.ADDR_WIDTH(5), .COUNT_WIDTH(2))  bus_b ();

    hazard_control_unit #(.FLUSH_CYCLES(2), .COUNT_WIDTH(16), .ADDR_WIDTH(5)) dut_a (
        .clk_i   (clk),
        .reset_i (reset),
        .hz      (bus_a)
    );

    hazard_control_unit #(.FLUSH_CYCLES(1), .COUNT_WIDTH(2), .ADDR_WIDTH(5)) dut_b (
        .clk_i   (clk),
        .reset_i (reset),
        .hz      (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic fl, input logic mem, input logic [4:0] dest,
                           input logic vld, input logic [2:0] used,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3);
        bus_a.flush_pipeline_i        = fl;
        bus_a.ex_mem_read_en_i        = mem;
        bus_a.ex_reg_dest_addr_i      = dest;
        bus_a.dec_is_valid_i          = vld;
        bus_a.dec_src_used_i          = used;
        bus_a.dec_reg_1_source_addr_i = s1;
        bus_a.dec_reg_2_source_addr_i = s2;
        bus_a.dec_reg_3_source_addr_i = s3;
    endtask

    task automatic drive_b(input logic fl, input logic mem, input logic [4:0] dest,
                           input logic vld, input logic [2:0] used,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3);
        bus_b.flush_pipeline_i        = fl;
        bus_b.ex_mem_read_en_i        = mem;
        bus_b.ex_reg_dest_addr_i      = dest;
        bus_b.dec_is_valid_i          = vld;
        bus_b.dec_src_used_i          = used;
        bus_b.dec_reg_1_source_addr_i = s1;
        bus_b.dec_reg_2_source_addr_i = s2;
        bus_b.dec_reg_3_source_addr_i = s3;
    endtask

    // {stall_fetch, stall_decode, invalidate}
    function automatic logic [2:0] outs_a();
        return {bus_a.stall_fetch_o, bus_a.stall_decode_o, bus_a.hazard_detector_invalidate_o};
    endfunction

    function automatic logic [2:0] outs_b();
        return {bus_b.stall_fetch_o, bus_b.stall_decode_o, bus_b.hazard_detector_invalidate_o};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        drive_a(1'b1, 1'b1, 5'd3, 1'b1, 3'b111, 5'd3, 5'd3, 5'd3);
        drive_b(1'b0, 1'b1, 5'd3, 1'b1, 3'b111, 5'd3, 5'd3, 5'd3);
        #1;
        checks++;
        if (outs_a() !== 3'b000) begin
            errors++; $display("FAIL reset_outs_a got %b exp 000", outs_a());
        end
        checks++;
        if (outs_b() !== 3'b000) begin
            errors++; $display("FAIL reset_outs_b got %b exp 000", outs_b());
        end
        tick();
        checks++;
        if (bus_a.stall_count_o !== 16'd0 || bus_a.flush_count_o !== 16'd0) begin
            errors++; $display("FAIL reset_counts_a got %0d/%0d exp 0/0",
                               bus_a.stall_count_o, bus_a.flush_count_o);
        end
        drive_a(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        drive_b(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        logic [2:0] used_v [3];
        logic [4:0] s1_v   [3];
        logic [4:0] s2_v   [3];
        logic [4:0] s3_v   [3];
        used_v = '{3'b001, 3'b100, 3'b010};
        s1_v   = '{5'd3, 5'd8, 5'd8};
        s2_v   = '{5'd7, 5'd9, 5'd3};
        s3_v   = '{5'd9, 5'd3, 5'd9};
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 1'b1, 5'd3, 1'b1, used_v[i], s1_v[i], s2_v[i], s3_v[i]);
            #1;
            checks++;
            if (outs_a() !== 3'b111) begin
                errors++; $display("FAIL load_use_hit[%0d] got %b exp 111", i, outs_a());
            end
            tick();
            // Still presenting the hit: LOAD_STALL must suppress it.
            #1;
            checks++;
            if (outs_a() !== 3'b000) begin
                errors++; $display("FAIL load_stall_suppress[%0d] got %b exp 000", i, outs_a());
            end
            checks++;
            if (bus_a.stall_count_o !== 16'(i + 1)) begin
                errors++; $display("FAIL stall_count[%0d] got %0d exp %0d", i, bus_a.stall_count_o, i + 1);
            end
            drive_a(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
            tick();
        end
    endtask

    task automatic test_no_hit();
        logic       mem_v  [6];
        logic       vld_v  [6];
        logic [2:0] used_v [6];
        logic [4:0] s1_v   [6];
        logic [4:0] s2_v   [6];
        logic [4:0] s3_v   [6];
        mem_v  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vld_v  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        used_v = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b010, 3'b001};
        s1_v   = '{5'd3, 5'd3, 5'd3, 5'd4, 5'd3, 5'd19};
        s2_v   = '{5'd3, 5'd3, 5'd3, 5'd5, 5'd5, 5'd3};
        s3_v   = '{5'd3, 5'd3, 5'd3, 5'd6, 5'd3, 5'd3};
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b0, mem_v[i], 5'd3, vld_v[i], used_v[i], s1_v[i], s2_v[i], s3_v[i]);
            #1;
            checks++;
            if (outs_a() !== 3'b000) begin
                errors++; $display("FAIL no_hit[%0d] got %b exp 000", i, outs_a());
            end
            tick();
        end
        drive_a(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        checks++;
        if (bus_a.stall_count_o !== 16'd3) begin
            errors++; $display("FAIL no_hit_count got %0d exp 3", bus_a.stall_count_o);
        end
        tick();
    endtask

    task automatic test_flush();
        drive_a(1'b1, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (outs_a() !== 3'b001) begin
            errors++; $display("FAIL flush_cycle got %b exp 001", outs_a());
        end
        tick();
        bus_a.flush_pipeline_i = 1'b0;
        #1;
        checks++;
        if (outs_a() !== 3'b001) begin
            errors++; $display("FAIL flush_drain got %b exp 001", outs_a());
        end
        checks++;
        if (bus_a.flush_count_o !== 16'd1) begin
            errors++; $display("FAIL flush_count got %0d exp 1", bus_a.flush_count_o);
        end
        tick();
        checks++;
        if (outs_a() !== 3'b000) begin
            errors++; $display("FAIL flush_end got %b exp 000", outs_a());
        end
    endtask

    task automatic test_flush_hit();
        drive_a(1'b1, 1'b1, 5'd3, 1'b1, 3'b001, 5'd3, 5'd0, 5'd0);
        #1;
        checks++;
        if (outs_a() !== 3'b001) begin
            errors++; $display("FAIL flush_hit_prio got %b exp 001", outs_a());
        end
        tick();
        bus_a.flush_pipeline_i = 1'b0;
        #1;
        checks++;
        if (outs_a() !== 3'b001) begin
            errors++; $display("FAIL drain_ignores_hit got %b exp 001", outs_a());
        end
        checks++;
        if (bus_a.stall_count_o !== 16'd3 || bus_a.flush_count_o !== 16'd2) begin
            errors++; $display("FAIL flush_hit_counts got %0d/%0d exp 3/2",
                               bus_a.stall_count_o, bus_a.flush_count_o);
        end
        tick();
        drive_a(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (outs_a() !== 3'b000) begin
            errors++; $display("FAIL flush_hit_end got %b exp 000", outs_a());
        end
        tick();
    endtask

    task automatic test_flush_in_drain();
        int inv_cycles;
        inv_cycles = 0;
        drive_a(1'b1, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) bus_a.flush_pipeline_i = 1'b0;
            #1;
            if (outs_a() == 3'b001) inv_cycles++;
            tick();
        end
        checks++;
        if (inv_cycles !== 3) begin
            errors++; $display("FAIL drain_restart_cycles got %0d exp 3", inv_cycles);
        end
        checks++;
        if (bus_a.flush_count_o !== 16'd4) begin
            errors++; $display("FAIL drain_restart_count got %0d exp 4", bus_a.flush_count_o);
        end
    endtask

    task automatic test_flush_in_load_stall();
        drive_a(1'b0, 1'b1, 5'd3, 1'b1, 3'b001, 5'd3, 5'd0, 5'd0);
        tick();
        bus_a.flush_pipeline_i = 1'b1;
        #1;
        checks++;
        if (outs_a() !== 3'b001) begin
            errors++; $display("FAIL flush_in_stall got %b exp 001", outs_a());
        end
        tick();
        drive_a(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (outs_a() !== 3'b001 || bus_a.stall_count_o !== 16'd4 || bus_a.flush_count_o !== 16'd5) begin
            errors++; $display("FAIL flush_in_stall_drain got %b %0d/%0d exp 001 4/5",
                               outs_a(), bus_a.stall_count_o, bus_a.flush_count_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        drive_a(1'b1, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        bus_a.flush_pipeline_i = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (outs_a() !== 3'b000) begin
            errors++; $display("FAIL reset_mid_drain_outs got %b exp 000", outs_a());
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (outs_a() !== 3'b000 || bus_a.stall_count_o !== 16'd0 || bus_a.flush_count_o !== 16'd0) begin
            errors++; $display("FAIL reset_mid_drain_after got %b %0d/%0d exp 000 0/0",
                               outs_a(), bus_a.stall_count_o, bus_a.flush_count_o);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            drive_b(1'b0, 1'b1, 5'd7, 1'b1, 3'b010, 5'd0, 5'd7, 5'd0);
            #1;
            checks++;
            if (outs_b() !== 3'b111) begin
                errors++; $display("FAIL sat_hit[%0d] got %b exp 111", i, outs_b());
            end
            tick();
            drive_b(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
            exp = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (bus_b.stall_count_o !== exp) begin
                errors++; $display("FAIL sat_stall_count[%0d] got %0d exp %0d", i, bus_b.stall_count_o, exp);
            end
            tick();
        end
        drive_b(1'b1, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (outs_b() !== 3'b001) begin
                errors++; $display("FAIL single_flush[%0d] got %b exp 001", i, outs_b());
            end
            tick();
            exp = (i >= 2) ? 2'd3 : 2'(i + 1);
            checks++;
            if (bus_b.flush_count_o !== exp) begin
                errors++; $display("FAIL sat_flush_count[%0d] got %0d exp %0d", i, bus_b.flush_count_o, exp);
            end
        end
        bus_b.flush_pipeline_i = 1'b0;
        #1;
        checks++;
        if (outs_b() !== 3'b000) begin
            errors++; $display("FAIL single_flush_no_drain got %b exp 000", outs_b());
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive_a(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        drive_b(1'b0, 1'b0, 5'd0, 1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        test_reset();
        test_load_use();
        test_no_hit();
        test_flush();
        test_flush_hit();
        test_flush_in_drain();
        test_flush_in_load_stall();
        test_reset_mid_drain();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
